cvxif_offload_unit: RTL and testbench

CVXIF_OFFLOAD_UNIT -- requirements
Module: cvxif_offload_unit

---
 rtl/config_pkg.sv | 13 +
 rtl/cvxif_pkg.sv | 78 +++++++
 rtl/cvxif_offload_unit.sv | 164 ++++++++++++++++
 tb/tb_cvxif_offload_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Core configuration shared by the CVA6-side blocks.
//   cva6_cfg_t     : configuration record (register width, scoreboard id width).
//   cva6_cfg_empty : default configuration (RV32, 3-bit transaction ids).
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 3};

endpackage

// File: rtl/cvxif_pkg.sv
// CORE-V eXtension interface types used between the core and a coprocessor.
//   cvxif_req_t  : core -> coprocessor (issue, commit, memory handshakes, result ready).
//   cvxif_resp_t : coprocessor -> core (issue ready/response, result).
//   exception_t  : writeback exception record.
package cvxif_pkg;

  localparam int unsigned X_NUM_RS    = 2;
  localparam int unsigned X_MAX_RS    = 3;
  localparam int unsigned X_ID_WIDTH  = 3;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_RFW_WIDTH = 32;
  localparam int unsigned X_MEM_WIDTH = 32;

  localparam int unsigned ILLEGAL_INSTR = 2;

  typedef struct packed {
    logic [X_RFW_WIDTH-1:0] cause;
    logic [X_RFW_WIDTH-1:0] tval;
    logic                   valid;
  } exception_t;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [1:0]                           mode;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_MAX_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_MAX_RS-1:0]                  rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
    logic                   dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef struct packed {
    logic         x_issue_valid;
    x_issue_req_t x_issue_req;
    logic         x_commit_valid;
    x_commit_t    x_commit;
    logic         x_mem_ready;
    logic         x_mem_result_valid;
    x_mem_resp_t  x_mem_resp;
    logic         x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

endpackage

// File: rtl/cvxif_offload_unit.sv
// Offloads instructions to a CV-X-IF coprocessor and merges its results
// into the core writeback path. Rejected instructions are queued and
// written back as illegal-instruction exceptions.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   x_valid_i / x_ready_o     : issue handshake from the core
//   x_off_instr_i, trans_id_i : instruction word and scoreboard id
//   operand_[abc]_i           : rs1/rs2/rs3 values
//   priv_lvl_i, flush_i       : privilege mode, pipeline flush
//   x_trans_id_o .. x_exception_o : writeback to the scoreboard
//   cvxif_req_o / cvxif_resp_i    : coprocessor interface
//   outstanding_o             : accepted instructions awaiting a result
module cvxif_offload_unit #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NumRs          = cvxif_pkg::X_NUM_RS,
  parameter int unsigned           IllegalDepth   = 4,
  parameter int unsigned           MaxOutstanding = 4,
  localparam int unsigned          TRANS_ID_BITS  = CVA6Cfg.TRANS_ID_BITS,
  localparam int unsigned          XLEN           = CVA6Cfg.XLEN,
  localparam int unsigned          OW             = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       x_valid_i,
  output logic                       x_ready_o,
  input  logic [31:0]                x_off_instr_i,
  input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
  input  logic [XLEN-1:0]            operand_a_i,
  input  logic [XLEN-1:0]            operand_b_i,
  input  logic [XLEN-1:0]            operand_c_i,
  input  logic [1:0]                 priv_lvl_i,
  input  logic                       flush_i,
  output logic [TRANS_ID_BITS-1:0]   x_trans_id_o,
  output logic [XLEN-1:0]            x_result_o,
  output logic                       x_valid_o,
  output logic                       x_we_o,
  output cvxif_pkg::exception_t      x_exception_o,
  output cvxif_pkg::cvxif_req_t      cvxif_req_o,
  input  cvxif_pkg::cvxif_resp_t     cvxif_resp_i,
  output logic [OW-1:0]              outstanding_o
);

  localparam int unsigned  PW      = $clog2(IllegalDepth);
  localparam int unsigned  CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IllegalDepth);
  localparam logic [OW-1:0] MAX_C   = OW'(MaxOutstanding);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [31:0]              instr;
  } ill_t;

  ill_t          mem_q [IllegalDepth];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;

  logic can_issue, fire, inc, push, pop, res, fwd, fifo_empty;
  logic unused_ok;

  assign fifo_empty = (cnt_q == '0);
  assign can_issue  = (out_q < MAX_C) && (cnt_q != DEPTH_C) && !flush_i;
  assign fire       = x_valid_i && can_issue && cvxif_resp_i.x_issue_ready;
  assign inc        = fire && cvxif_resp_i.x_issue_resp.accept;
  assign push       = fire && !cvxif_resp_i.x_issue_resp.accept;
  assign res        = cvxif_resp_i.x_result_valid;
  // Writeback is combinational, so it is gated by rst_ni to stay quiet
  // throughout reset even if the coprocessor presents a result.
  assign fwd        = res && (drop_q == '0) && rst_ni;
  assign pop        = !fwd && !fifo_empty;

  assign x_ready_o     = cvxif_resp_i.x_issue_ready && can_issue;
  assign outstanding_o = out_q;
  assign unused_ok     = ^{cvxif_resp_i, operand_c_i};

  always_comb begin
    cvxif_req_o                       = '0;
    cvxif_req_o.x_issue_valid         = x_valid_i && can_issue;
    cvxif_req_o.x_issue_req.instr     = x_off_instr_i;
    cvxif_req_o.x_issue_req.mode      = priv_lvl_i;
    cvxif_req_o.x_issue_req.id        = trans_id_i;
    cvxif_req_o.x_issue_req.rs[0]     = operand_a_i;
    cvxif_req_o.x_issue_req.rs[1]     = operand_b_i;
    cvxif_req_o.x_issue_req.rs_valid[0] = 1'b1;
    cvxif_req_o.x_issue_req.rs_valid[1] = 1'b1;
    if (NumRs == 3) begin
      cvxif_req_o.x_issue_req.rs[2]       = operand_c_i;
      cvxif_req_o.x_issue_req.rs_valid[2] = 1'b1;
    end
    cvxif_req_o.x_commit_valid        = fire;
    cvxif_req_o.x_commit.id           = trans_id_i;
    cvxif_req_o.x_commit.x_kill       = 1'b0;
    cvxif_req_o.x_result_ready        = 1'b1;
  end

  // Outstanding count saturates at zero; a flush snapshots the post-update
  // count so exactly that many in-flight results are swallowed.
  always_comb begin
    out_d = out_q;
    if (inc && !res)                       out_d = out_q + OW'(1);
    else if (!inc && res && out_q != '0)   out_d = out_q - OW'(1);
    drop_d = drop_q;
    if (flush_i)                           drop_d = out_d;
    else if (res && drop_q != '0)          drop_d = drop_q - OW'(1);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    x_valid_o     = 1'b0;
    x_trans_id_o  = '0;
    x_result_o    = '0;
    x_we_o        = 1'b0;
    x_exception_o = '0;
    if (fwd) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = cvxif_resp_i.x_result.id;
      x_result_o          = cvxif_resp_i.x_result.data;
      x_we_o              = cvxif_resp_i.x_result.we;
      x_exception_o.valid = cvxif_resp_i.x_result.exc;
      x_exception_o.cause = XLEN'(cvxif_resp_i.x_result.exccode);
    end else if (!fifo_empty) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = mem_q[rd_ptr_q].id;
      x_exception_o.valid = 1'b1;
      x_exception_o.cause = XLEN'(cvxif_pkg::ILLEGAL_INSTR);
      x_exception_o.tval  = XLEN'(mem_q[rd_ptr_q].instr);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{id: trans_id_i, instr: x_off_instr_i};
  end

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// Self-checking bench for cvxif_offload_unit: directed vector table,
// hand-written flush/backpressure/reset sequences, then random traffic,
// all checked against a queue-based reference model.
module tb_cvxif_offload_unit;
  import cvxif_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid, flush, iready, acc, rv, rwe, rexc;
  logic [31:0] instr, opa, opb, opc, rdata;
  logic [2:0]  tid, rid;
  logic [1:0]  priv;
  logic [5:0]  rcode;

  logic        x_ready, wv, wwe;
  logic [2:0]  wid;
  logic [31:0] wres;
  exception_t  wexc;
  cvxif_req_t  creq;
  cvxif_resp_t cresp;
  logic [2:0]  outst;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] instr;
  } ent_t;

  int   m_out, m_drop;
  ent_t m_fifo[$];

  typedef struct {
    bit          v, a, r;
    int          id;
    logic [31:0] ins;
    int          rid;
    int          e_rdy, e_wv, e_wid, e_cause, e_out;
  } vec_t;

  vec_t tab[13];

  always #5 clk = ~clk;

  always_comb begin
    cresp                     = '0;
    cresp.x_issue_ready       = iready;
    cresp.x_issue_resp.accept = acc;
    cresp.x_result_valid      = rv;
    cresp.x_result.id         = rid;
    cresp.x_result.data       = rdata;
    cresp.x_result.we         = rwe;
    cresp.x_result.exc        = rexc;
    cresp.x_result.exccode    = rcode;
  end

  cvxif_offload_unit #(
    .IllegalDepth  (4),
    .MaxOutstanding(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .x_valid_i    (x_valid),
    .x_ready_o    (x_ready),
    .x_off_instr_i(instr),
    .trans_id_i   (tid),
    .operand_a_i  (opa),
    .operand_b_i  (opb),
    .operand_c_i  (opc),
    .priv_lvl_i   (priv),
    .flush_i      (flush),
    .x_trans_id_o (wid),
    .x_result_o   (wres),
    .x_valid_o    (wv),
    .x_we_o       (wwe),
    .x_exception_o(wexc),
    .cvxif_req_o  (creq),
    .cvxif_resp_i (cresp),
    .outstanding_o(outst)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    x_valid = 1'b0; flush = 1'b0; iready = 1'b1; acc = 1'b0;
    rv = 1'b0; rwe = 1'b0; rexc = 1'b0; rcode = '0; rid = '0; rdata = '0;
    instr = '0; tid = '0; priv = 2'd3;
    opa = 32'h1111_1111; opb = 32'h2222_2222; opc = 32'h3333_3333;
  endtask

  // One clock cycle: inputs are already driven; outputs are sampled at the
  // falling edge, compared with the model (and optional explicit values),
  // then the model advances to the state after the rising edge.
  task automatic cycle(input int e_rdy, input int e_wv, input int e_wid,
                       input int e_cause, input int e_out);
    logic        can, fire, fwd, e_v, e_we, e_xv;
    logic [2:0]  e_id;
    logic [31:0] e_dat, e_cs, e_tv;
    int          nxt;
    @(negedge clk);
    can  = (m_out < 4) && (m_fifo.size() < 4) && !flush;
    fire = x_valid && iready && can;
    fwd  = rv && (m_drop == 0);
    e_v = 1'b0; e_id = '0; e_dat = '0; e_we = 1'b0; e_xv = 1'b0; e_cs = '0; e_tv = '0;
    if (fwd) begin
      e_v = 1'b1; e_id = rid; e_dat = rdata; e_we = rwe; e_xv = rexc; e_cs = {26'd0, rcode};
    end else if (m_fifo.size() > 0) begin
      e_v = 1'b1; e_id = m_fifo[0].id; e_xv = 1'b1; e_cs = 32'd2; e_tv = m_fifo[0].instr;
    end
    chk("x_ready", x_ready, iready && can);
    chk("issue_valid", creq.x_issue_valid, x_valid && can);
    chk("issue_instr", creq.x_issue_req.instr, instr);
    chk("issue_id", creq.x_issue_req.id, tid);
    chk("issue_mode", creq.x_issue_req.mode, priv);
    chk("issue_rs", {creq.x_issue_req.rs[1], creq.x_issue_req.rs[0]}, {opb, opa});
    chk("rs_valid", creq.x_issue_req.rs_valid[1:0], 2'b11);
    chk("commit_valid", creq.x_commit_valid, fire);
    chk("commit_id_kill", {creq.x_commit.id, creq.x_commit.x_kill}, {tid, 1'b0});
    chk("tied_ctrl", {creq.x_result_ready, creq.x_mem_ready, creq.x_mem_result_valid}, 3'b100);
    chk("wb_valid", wv, e_v);
    chk("wb_id", wid, e_id);
    chk("wb_data", wres, e_dat);
    chk("wb_we", wwe, e_we);
    chk("exc_valid", wexc.valid, e_xv);
    chk("exc_cause", wexc.cause, e_cs);
    chk("exc_tval", wexc.tval, e_tv);
    chk("outstanding", outst, m_out);
    if (e_rdy >= 0)   chk("tab_ready", x_ready, e_rdy);
    if (e_wv >= 0)    chk("tab_wb_valid", wv, e_wv);
    if (e_wid >= 0)   chk("tab_wb_id", wid, e_wid);
    if (e_cause >= 0) chk("tab_cause", wexc.cause, e_cause);
    if (e_out >= 0)   chk("tab_outstanding", outst, e_out);

    if (!fwd && m_fifo.size() > 0) void'(m_fifo.pop_front());
    nxt = m_out + int'(fire && acc) - int'(rv);
    if (nxt < 0) nxt = 0;
    if (rv && m_drop > 0) m_drop--;
    if (flush) begin
      m_fifo.delete();
      m_drop = nxt;
    end
    if (fire && !acc) m_fifo.push_back('{id: tid, instr: instr});
    m_out = nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             v  a  r  id ins           rid rdy wv wid cause out
    tab[0]  = '{1, 0, 0, 3, 32'h0000_000B, 0,  1,  0, 0,  0,    0};
    tab[1]  = '{0, 0, 0, 0, 32'h0,         0,  1,  1, 3,  2,    0};
    tab[2]  = '{1, 1, 0, 0, 32'h0000_010B, 0,  1,  0, 0,  0,    0};
    tab[3]  = '{1, 1, 0, 1, 32'h0000_020B, 0,  1,  0, 0,  0,    1};
    tab[4]  = '{1, 1, 0, 2, 32'h0000_030B, 0,  1,  0, 0,  0,    2};
    tab[5]  = '{1, 1, 0, 3, 32'h0000_040B, 0,  1,  0, 0,  0,    3};
    tab[6]  = '{1, 1, 0, 4, 32'h0000_050B, 0,  0,  0, 0,  0,    4};
    tab[7]  = '{0, 0, 1, 0, 32'h0,         0,  0,  1, 0,  0,    4};
    tab[8]  = '{0, 0, 0, 0, 32'h0,         0,  1,  0, 0,  0,    3};
    tab[9]  = '{1, 0, 0, 2, 32'h0000_002B, 0,  1,  0, 0,  0,    3};
    tab[10] = '{0, 0, 1, 0, 32'h0,         5,  1,  1, 5,  0,    3};
    tab[11] = '{0, 0, 0, 0, 32'h0,         0,  1,  1, 2,  2,    2};
    tab[12] = '{0, 0, 0, 0, 32'h0,         0,  1,  0, 0,  0,    2};

    m_out = 0; m_drop = 0; m_fifo.delete();
    set_idle();
    rst_n = 1'b0;
    rv = 1'b1; rid = 3'd5; rdata = 32'hDEAD_BEEF; rwe = 1'b1;
    #12;
    chk("reset_wb_valid", wv, 1'b0);
    chk("reset_wb_id", wid, 3'd0);
    chk("reset_wb_data", wres, 32'd0);
    chk("reset_outstanding", outst, 3'd0);
    set_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      x_valid = tab[i].v; acc = tab[i].a; rv = tab[i].r;
      tid = 3'(tab[i].id); instr = tab[i].ins; rid = 3'(tab[i].rid);
      rdata = 32'hD000 + 32'(tab[i].rid); rwe = 1'b1;
      cycle(tab[i].e_rdy, tab[i].e_wv, tab[i].e_wid, tab[i].e_cause, tab[i].e_out);
    end
    set_idle();

    // Flush with one queued illegal entry and two in-flight results.
    x_valid = 1'b1; acc = 1'b1; tid = 3'd1; instr = 32'h0000_110B;
    cycle(1, 0, -1, -1, 2);
    x_valid = 1'b1; acc = 1'b0; tid = 3'd6; instr = 32'h0000_060B;
    cycle(1, 0, -1, -1, 3);
    x_valid = 1'b0; flush = 1'b1; rv = 1'b1; rid = 3'd5; rdata = 32'hA5A5_0005;
    cycle(0, 1, 5, 0, 3);
    flush = 1'b0; rv = 1'b0;
    cycle(1, 0, -1, -1, 2);
    rv = 1'b1; rid = 3'd0; rdata = 32'hA5A5_0000;
    cycle(-1, 0, -1, -1, 2);
    rid = 3'd1; rdata = 32'hA5A5_0001;
    cycle(-1, 0, -1, -1, 1);
    rid = 3'd4; rdata = 32'hA5A5_0004;
    cycle(-1, 1, 4, 0, 0);
    set_idle();

    // Fill the illegal FIFO while results hold writeback, then drain in order.
    rv = 1'b1; rid = 3'd7; rdata = 32'h7777_0007;
    for (int k = 0; k < 5; k++) begin
      x_valid = 1'b1; acc = 1'b0; tid = 3'(k); instr = 32'h100 * 32'(k) + 32'hB;
      cycle((k < 4) ? 1 : 0, 1, 7, -1, 0);
    end
    set_idle();
    for (int k = 0; k < 4; k++) cycle(-1, 1, k, 2, -1);
    cycle(-1, 0, -1, -1, -1);

    // Asynchronous reset with two queued illegal entries.
    rv = 1'b1; rid = 3'd7;
    for (int k = 1; k < 3; k++) begin
      x_valid = 1'b1; acc = 1'b0; tid = 3'(k); instr = 32'h100 * 32'(k) + 32'hB;
      cycle(1, 1, 7, -1, 0);
    end
    x_valid = 1'b0; rid = 3'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", wv, 1'b0);
    chk("arst_outstanding", outst, 3'd0);
    rv = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_out = 0; m_drop = 0; m_fifo.delete();
    cycle(1, 0, -1, -1, 0);
    rv = 1'b1; rid = 3'd3; rdata = 32'h3333_0003; rwe = 1'b1;
    cycle(-1, 1, 3, 0, 0);
    set_idle();

    for (int k = 0; k < 600; k++) begin
      x_valid = 1'($urandom);
      acc     = 1'($urandom);
      iready  = ($urandom_range(3) != 0);
      rv      = ($urandom_range(2) == 0);
      flush   = ($urandom_range(19) == 0);
      tid     = 3'($urandom);
      rid     = 3'($urandom);
      instr   = $urandom;
      rdata   = $urandom;
      rwe     = 1'($urandom);
      rexc    = ($urandom_range(3) == 0);
      rcode   = 6'($urandom);
      opa     = $urandom;
      opb     = $urandom;
      opc     = $urandom;
      priv    = 2'($urandom);
      cycle(-1, -1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
